// File: rtl/match_table_ctrl.sv
// Sequencing controller for a small match table: runs one lookup/insert/delete/flush
// command at a time and returns hit, lowest index, match mask and occupancy.
module match_table_ctrl #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned WIDTH = 4,
  localparam int unsigned IW = $clog2(SIZE),
  localparam int unsigned CW = $clog2(SIZE + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [WIDTH-1:0]             cmd_value,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_ok,
  output logic                         rsp_hit,
  output logic [IW-1:0]                rsp_index,
  output logic [SIZE-1:0]              rsp_mask,
  output logic [CW-1:0]                occupancy,
  output logic [SIZE-1:0][WIDTH:0]     table_q
);

  localparam logic [1:0] OpLookup = 2'b00;
  localparam logic [1:0] OpInsert = 2'b01;
  localparam logic [1:0] OpDelete = 2'b10;
  localparam logic [1:0] OpFlush  = 2'b11;

  typedef enum logic [1:0] {StIdle, StExec, StFlush, StResp} state_e;

  state_e           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] value_q;
  logic [IW-1:0]    ptr_q;

  logic [SIZE-1:0]  mask;
  logic             hit;
  logic [IW-1:0]    match_idx;
  logic [IW-1:0]    free_idx;
  logic             has_free;
  logic [CW-1:0]    pop;

  // Entry layout is {valid, value}; the valid bit sits at position WIDTH.
  always_comb begin
    mask      = '0;
    match_idx = '0;
    free_idx  = '0;
    has_free  = 1'b0;
    pop       = '0;
    for (int i = 0; i < int'(SIZE); i++) begin
      mask[i] = table_q[i][WIDTH] && (table_q[i][WIDTH-1:0] == value_q);
      pop     = pop + CW'(mask[i]);
    end
    // Scan downwards so the lowest index wins.
    for (int i = int'(SIZE) - 1; i >= 0; i--) begin
      if (mask[i]) match_idx = IW'(i);
      if (!table_q[i][WIDTH]) begin
        free_idx = IW'(i);
        has_free = 1'b1;
      end
    end
    hit = |mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= OpLookup;
      value_q   <= '0;
      ptr_q     <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_ok    <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_index <= '0;
      rsp_mask  <= '0;
      occupancy <= '0;
      table_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            value_q   <= cmd_value;
            cmd_ready <= 1'b0;
            state_q   <= (cmd_op == OpFlush) ? StFlush : StExec;
          end
        end
        StExec: begin
          rsp_hit   <= hit;
          rsp_mask  <= mask;
          rsp_index <= match_idx;
          rsp_ok    <= hit;
          rsp_valid <= 1'b1;
          state_q   <= StResp;
          case (op_q)
            OpLookup: ;
            OpInsert: begin
              if (hit) begin
                rsp_ok <= 1'b1;
              end else if (has_free) begin
                table_q[free_idx] <= {1'b1, value_q};
                rsp_index         <= free_idx;
                rsp_ok            <= 1'b1;
                occupancy         <= occupancy + CW'(1);
              end else begin
                rsp_ok    <= 1'b0;
                rsp_index <= '0;
              end
            end
            OpDelete: begin
              // Only the valid bit is cleared; stale value bits never match again.
              for (int i = 0; i < int'(SIZE); i++) begin
                if (mask[i]) table_q[i][WIDTH] <= 1'b0;
              end
              occupancy <= occupancy - pop;
            end
            default: ;
          endcase
        end
        StFlush: begin
          if (table_q[ptr_q][WIDTH]) begin
            table_q[ptr_q][WIDTH] <= 1'b0;
            occupancy             <= occupancy - CW'(1);
          end
          if (ptr_q == IW'(SIZE - 1)) begin
            ptr_q     <= '0;
            rsp_ok    <= 1'b1;
            rsp_hit   <= 1'b0;
            rsp_mask  <= '0;
            rsp_index <= '0;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else begin
            ptr_q <= ptr_q + IW'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/match_table_ctrl.md
Name: match_table_ctrl

Overview:
- Sequencing controller for a SIZE-entry match table of data_t entries ({valid, value}).
- Accepts lookup, insert, delete and flush commands over a valid/ready interface and runs one command at a time.
- Computes the per-entry match mask internally: bit i = table[i].valid && table[i].value == operand.
- Returns the hit, the lowest matching index, the full mask and the occupancy over a valid/ready response interface.
- Sits between software-facing command logic and the matching datapath.

Parameters:
- SIZE, 8, number of table entries (>=2).
- WIDTH, 4, width of data_t.value and of cmd_value.
- IW, $clog2(SIZE), index width (localparam).
- CW, $clog2(SIZE+1), occupancy width (localparam).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  2  00 LOOKUP, 01 INSERT, 10 DELETE, 11 FLUSH.
- cmd_value  input  WIDTH  operand value (ignored for FLUSH).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_ok  output  1  command succeeded.
- rsp_hit  output  1  operand matched at least one valid entry, evaluated before any write.
- rsp_index  output  IW  LOOKUP/DELETE: lowest matching index; INSERT: written or existing index.
- rsp_mask  output  SIZE  match mask, evaluated before any write.
- occupancy  output  CW  count of valid entries, registered.
- table_q  output  data_t [SIZE-1:0]  current table contents, for observation.

Behaviour:
- Reset (asynchronous): state=IDLE; all table entries valid=0, value=0; cmd_ready=1; rsp_valid=0; rsp_ok/hit/index/mask=0; occupancy=0; flush pointer=0.
- FSM states: IDLE, EXEC, FLUSH, RESP.
- IDLE
  - cmd_ready=1.
  - On cmd_valid: register op and value.
  - Go to FLUSH if op=11, otherwise to EXEC.
- EXEC (1 cycle): mask computed from the registered value and the current table.
  - LOOKUP: ok=hit; index=lowest set mask bit (0 if none); table unchanged.
  - INSERT, hit: no write; ok=1; index=lowest match. Duplicates are never created.
  - INSERT, miss and a free slot exists: write {1,value} at the lowest index with valid=0; ok=1; index=that slot; occupancy+1.
  - INSERT, miss and table full: no write; ok=0; index=0.
  - DELETE: clear valid of every masked entry; value bits are kept; ok=hit; index=lowest match; occupancy minus popcount(mask).
  - Response registers load at the end of EXEC. Next state is RESP.
- FLUSH
  - Clears valid of entry[ptr] each cycle; ptr runs 0..SIZE-1, which takes exactly SIZE cycles.
  - occupancy decrements for each entry cleared while valid.
  - After entry SIZE-1: ptr=0; response ok=1, hit=0, mask=0, index=0; go to RESP.
- RESP
  - rsp_valid=1; response fields are held stable until rsp_ready=1.
  - On handshake, go to IDLE; rsp_valid falls the next cycle.
- cmd_ready=0 in EXEC, FLUSH and RESP. Commands presented then are not accepted and must be held by the source.
- Latency: command accepted at edge N gives rsp_valid high after edge N+1 (non-flush) or after edge N+SIZE (flush).
- Back-to-back: rsp_ready held at 1 gives one command per 3 cycles.
- Occupancy stays within 0..SIZE. Table writes happen only in EXEC or FLUSH.
- Reset asserted mid-command or mid-flush: immediate return to reset values. The pending response is discarded.
- X on cmd_op/cmd_value while cmd_valid=0 must not affect state.

Test Plan:
SIZE=4, WIDTH=4.
- Reset, then INSERT 3,5,10,3 -> responses ok=1 index=0,1,2 then 4th ok=1 hit=1 index=0; occupancy=3.
- With {3,5,10}, INSERT 7 then INSERT 9 -> 7 ok=1 index=3; 9 ok=0 hit=0; occupancy=4 and the table is unchanged.
- With {3,5,10,7}, LOOKUP 5 -> hit=1 mask=0010 index=1. LOOKUP 4 -> hit=0 mask=0000 ok=0.
- DELETE 5, then INSERT 12 -> delete gives mask=0010 occupancy=3; insert reuses index=1. LOOKUP 12 -> mask=0010.
- Hold rsp_ready=0 for 5 cycles after a LOOKUP -> rsp fields stable; cmd_ready=0 and a pending cmd_valid is not accepted. Release -> command accepted 1 cycle after rsp_valid falls.
- FLUSH on a full table with rst pulsed at flush cycle 2 -> all outputs return to reset values asynchronously. Repeat without reset -> rsp_valid after 4 FLUSH cycles, occupancy=0, all valid=0.
